// File: rtl/sys_array_tile_planner.sv
`default_nettype none
// ============================================================================
// Module      : sys_array_tile_planner
// Description : Streams the inclusive index ranges of every systolic-array
//               sized sub-problem of O[MxN] = A[MxK] * B[KxN], K innermost,
//               with first/last-K flags for the downstream accumulator and a
//               selectable outer loop order. One tile per valid/ready beat.
// Revision    : 1.0 - initial release
// ============================================================================
module sys_array_tile_planner #(
  parameter int DIM_W  = 16,
  parameter int TILE_M = 10,
  parameter int TILE_K = 10,
  parameter int TILE_N = 10,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [DIM_W-1:0] mat_m,
  input  logic [DIM_W-1:0] mat_k,
  input  logic [DIM_W-1:0] mat_n,
  input  logic             order,
  output logic             tile_valid,
  input  logic             tile_ready,
  output logic [DIM_W-1:0] a_row0,
  output logic [DIM_W-1:0] a_row1,
  output logic [DIM_W-1:0] k0,
  output logic [DIM_W-1:0] k1,
  output logic [DIM_W-1:0] b_col0,
  output logic [DIM_W-1:0] b_col1,
  output logic             first_k,
  output logic             last_k,
  output logic [CNT_W-1:0] tile_idx,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EMIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [DIM_W-1:0] STEP_M = DIM_W'(TILE_M);
  localparam logic [DIM_W-1:0] STEP_K = DIM_W'(TILE_K);
  localparam logic [DIM_W-1:0] STEP_N = DIM_W'(TILE_N);
  localparam logic [DIM_W:0]   ONE_W  = (DIM_W+1)'(1);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  // End of a range: min(base + step, dim) - 1, evaluated one bit wider so a
  // base near the top of the dimension range cannot wrap.
  function automatic logic [DIM_W-1:0] range_end(input logic [DIM_W-1:0] base,
                                                 input logic [DIM_W-1:0] step,
                                                 input logic [DIM_W-1:0] dim);
    logic [DIM_W:0] sum;
    logic [DIM_W:0] lim;
    sum = {1'b0, base} + {1'b0, step};
    lim = (sum < {1'b0, dim}) ? sum : {1'b0, dim};
    return DIM_W'(lim - ONE_W);
  endfunction

  // True when this base is the final slice of the dimension.
  function automatic logic is_last(input logic [DIM_W-1:0] base,
                                   input logic [DIM_W-1:0] step,
                                   input logic [DIM_W-1:0] dim);
    return ({1'b0, base} + {1'b0, step}) >= {1'b0, dim};
  endfunction

  logic [1:0]       state, state_nxt;
  logic [DIM_W-1:0] m_dim, k_dim, n_dim;
  logic [DIM_W-1:0] m_dim_nxt, k_dim_nxt, n_dim_nxt;
  logic             ord, ord_nxt;
  logic [DIM_W-1:0] m_base, k_base, n_base;
  logic [DIM_W-1:0] m_base_nxt, k_base_nxt, n_base_nxt;
  logic             accept, reject, fire;
  logic             m_last, k_last, n_last;

  // Output next values, registered below so every port comes from a flop.
  logic             valid_nxt, done_nxt, err_nxt;
  logic [DIM_W-1:0] a_row1_nxt, k1_nxt, b_col1_nxt;
  logic             first_k_nxt, last_k_nxt;
  logic [CNT_W-1:0] idx_nxt;

  assign fire   = tile_valid & tile_ready;
  assign m_last = is_last(m_base, STEP_M, m_dim);
  assign k_last = is_last(k_base, STEP_K, k_dim);
  assign n_last = is_last(n_base, STEP_N, n_dim);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next state and loop-counter advance: K innermost, then middle, then outer.
  always_comb begin
    state_nxt  = state;
    m_dim_nxt  = m_dim;
    k_dim_nxt  = k_dim;
    n_dim_nxt  = n_dim;
    ord_nxt    = ord;
    m_base_nxt = m_base;
    k_base_nxt = k_base;
    n_base_nxt = n_base;
    accept     = 1'b0;
    reject     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          m_dim_nxt  = mat_m;
          k_dim_nxt  = mat_k;
          n_dim_nxt  = mat_n;
          ord_nxt    = order;
          m_base_nxt = '0;
          k_base_nxt = '0;
          n_base_nxt = '0;
          if (mat_m == '0 || mat_k == '0 || mat_n == '0) begin
            reject    = 1'b1;
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        if (fire) begin
          if (!k_last) begin
            k_base_nxt = k_base + STEP_K;
          end else begin
            k_base_nxt = '0;
            if (!ord) begin
              // N outer, M middle
              if (!m_last) begin
                m_base_nxt = m_base + STEP_M;
              end else begin
                m_base_nxt = '0;
                if (!n_last) n_base_nxt = n_base + STEP_N;
                else         state_nxt  = S_DONE;
              end
            end else begin
              // M outer, N middle
              if (!n_last) begin
                n_base_nxt = n_base + STEP_N;
              end else begin
                n_base_nxt = '0;
                if (!m_last) m_base_nxt = m_base + STEP_M;
                else         state_nxt  = S_DONE;
              end
            end
          end
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output next values derived from the upcoming counters and dimensions.
  always_comb begin
    valid_nxt   = (state_nxt == S_EMIT);
    done_nxt    = (state_nxt == S_DONE);
    err_nxt     = reject;
    a_row1_nxt  = range_end(m_base_nxt, STEP_M, m_dim_nxt);
    k1_nxt      = range_end(k_base_nxt, STEP_K, k_dim_nxt);
    b_col1_nxt  = range_end(n_base_nxt, STEP_N, n_dim_nxt);
    first_k_nxt = (k_base_nxt == '0);
    last_k_nxt  = is_last(k_base_nxt, STEP_K, k_dim_nxt);
    idx_nxt     = tile_idx;
    if (accept)    idx_nxt = '0;
    else if (fire) idx_nxt = tile_idx + ONE_C;
  end

  // Datapath and registered outputs; tile fields only reload when a tile
  // will be presented, so they hold steady under backpressure.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      m_dim      <= '0;
      k_dim      <= '0;
      n_dim      <= '0;
      ord        <= 1'b0;
      m_base     <= '0;
      k_base     <= '0;
      n_base     <= '0;
      tile_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      tile_idx   <= '0;
      a_row0     <= '0;
      a_row1     <= '0;
      k0         <= '0;
      k1         <= '0;
      b_col0     <= '0;
      b_col1     <= '0;
      first_k    <= 1'b0;
      last_k     <= 1'b0;
    end else begin
      m_dim      <= m_dim_nxt;
      k_dim      <= k_dim_nxt;
      n_dim      <= n_dim_nxt;
      ord        <= ord_nxt;
      m_base     <= m_base_nxt;
      k_base     <= k_base_nxt;
      n_base     <= n_base_nxt;
      tile_valid <= valid_nxt;
      busy       <= valid_nxt;
      done       <= done_nxt;
      err        <= err_nxt;
      tile_idx   <= idx_nxt;
      if (valid_nxt) begin
        a_row0  <= m_base_nxt;
        a_row1  <= a_row1_nxt;
        k0      <= k_base_nxt;
        k1      <= k1_nxt;
        b_col0  <= n_base_nxt;
        b_col1  <= b_col1_nxt;
        first_k <= first_k_nxt;
        last_k  <= last_k_nxt;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sys_array_tile_planner.sv
`default_nettype none
// ============================================================================
// Module      : tb_sys_array_tile_planner
// Description : Self-checking bench for sys_array_tile_planner with a
//               loop-nest reference model and randomized ready/dimensions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sys_array_tile_planner;

  localparam int T = 10;
  localparam int LIMIT = 20000;

  typedef struct packed {
    logic [15:0] a0, a1, c0, c1, b0, b1;
    logic        fk, lk;
    logic [15:0] idx;
  } tile_t;

  logic        clk = 0, reset_n = 0, start = 0, order = 0, tile_ready = 0;
  logic [15:0] mat_m = 0, mat_k = 0, mat_n = 0;
  logic        tile_valid, first_k, last_k, busy, done, err;
  logic [15:0] a_row0, a_row1, k0, k1, b_col0, b_col1, tile_idx;

  int errors = 0, checks = 0;
  tile_t exp_q[$], obs_q[$];
  int    got_done, got_err, busy_at_done, valid_at_done, done_next;
  int    v_t1, b_t1, hs_last, done_cyc, timed_out;

  sys_array_tile_planner dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .mat_m(mat_m), .mat_k(mat_k), .mat_n(mat_n), .order(order),
    .tile_valid(tile_valid), .tile_ready(tile_ready),
    .a_row0(a_row0), .a_row1(a_row1), .k0(k0), .k1(k1),
    .b_col0(b_col0), .b_col1(b_col1), .first_k(first_k), .last_k(last_k),
    .tile_idx(tile_idx), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic tile_t cur_tile();
    return '{a_row0, a_row1, k0, k1, b_col0, b_col1, first_k, last_k, tile_idx};
  endfunction

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  // Reference: plain loop nest over tile indices, K innermost.
  function automatic void build_plan(int m, int k, int n, bit ord);
    int nm, nk, nn, no, nmid, idx, mi, ni;
    tile_t t;
    exp_q.delete();
    nm = (m + T - 1) / T; nk = (k + T - 1) / T; nn = (n + T - 1) / T;
    no = ord ? nm : nn; nmid = ord ? nn : nm; idx = 0;
    for (int o = 0; o < no; o++)
      for (int md = 0; md < nmid; md++)
        for (int kk = 0; kk < nk; kk++) begin
          mi = ord ? o : md; ni = ord ? md : o;
          t.a0 = 16'(mi * T); t.a1 = 16'(imin((mi + 1) * T, m) - 1);
          t.c0 = 16'(kk * T); t.c1 = 16'(imin((kk + 1) * T, k) - 1);
          t.b0 = 16'(ni * T); t.b1 = 16'(imin((ni + 1) * T, n) - 1);
          t.fk = (kk == 0); t.lk = (kk == nk - 1); t.idx = 16'(idx);
          exp_q.push_back(t); idx++;
        end
  endfunction

  // Collects handshaked tiles at negedges until done is seen or the budget runs out.
  task automatic collect(input int pct);
    int cyc;
    bit rdy;
    cyc = 0;
    forever begin
      if (done) begin
        got_done = 1; got_err = err; busy_at_done = busy;
        valid_at_done = tile_valid; done_cyc = cyc;
        break;
      end
      if (cyc >= LIMIT) begin timed_out = 1; break; end
      rdy = ($urandom_range(99) < pct);
      tile_ready = rdy;
      if (tile_valid && rdy) begin obs_q.push_back(cur_tile()); hs_last = cyc; end
      @(negedge clk); cyc++;
    end
    tile_ready = 0;
    @(negedge clk);
    done_next = done;
  endtask

  task automatic launch(input int m, input int k, input int n, input bit ord);
    obs_q.delete();
    got_done = 0; got_err = 0; timed_out = 0; hs_last = -100; done_cyc = -1;
    @(negedge clk);
    mat_m = 16'(m); mat_k = 16'(k); mat_n = 16'(n); order = ord; start = 1;
    @(negedge clk);
    start = 0; v_t1 = tile_valid; b_t1 = busy;
  endtask

  task automatic run_plan(input int m, input int k, input int n, input bit ord, input int pct);
    build_plan(m, k, n, ord);
    launch(m, k, n, ord);
    collect(pct);
  endtask

  task automatic test_reset();
    reset_n = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tile_valid, busy, done, err, first_k, last_k, tile_idx, a_row0, a_row1,
         k0, k1, b_col0, b_col1} !== '0) begin
      errors++;
      $display("FAIL reset_values: got valid=%b busy=%b done=%b err=%b idx=%0d rows=%0d..%0d expected all zero",
               tile_valid, busy, done, err, tile_idx, a_row0, a_row1);
    end
    reset_n = 1;
    @(negedge clk);
  endtask

  task automatic test_single();
    tile_t want;
    run_plan(10, 10, 10, 0, 100);
    want = '{16'd0, 16'd9, 16'd0, 16'd9, 16'd0, 16'd9, 1'b1, 1'b1, 16'd0};
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== want) begin
      errors++;
      $display("FAIL single_tile: got n=%0d tile=%h expected 1 tile %h", obs_q.size(),
               (obs_q.size() > 0) ? obs_q[0] : tile_t'(0), want);
    end
    checks++;
    if (v_t1 !== 1 || b_t1 !== 1) begin
      errors++; $display("FAIL first_tile_latency: got valid=%0d busy=%0d expected 1 1", v_t1, b_t1);
    end
    checks++;
    if (!got_done || done_cyc != hs_last + 1 || valid_at_done != 0 || busy_at_done != 0 || done_next != 0) begin
      errors++;
      $display("FAIL single_done: got done=%0d at %0d (hs %0d) valid=%0d busy=%0d next=%0d expected pulse hs+1",
               got_done, done_cyc, hs_last, valid_at_done, busy_at_done, done_next);
    end
  endtask

  task automatic test_row_split();
    run_plan(25, 10, 10, 0, 100);
    checks++;
    if (obs_q.size() != 3) begin
      errors++; $display("FAIL row_split_count: got %0d expected 3", obs_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_q[i].a0 != 16'(i * 10) || obs_q[i].a1 != 16'((i == 2) ? 24 : i * 10 + 9) ||
            obs_q[i].fk !== 1 || obs_q[i].lk !== 1 || obs_q[i].idx != 16'(i)) begin
          errors++;
          $display("FAIL row_split_tile%0d: got rows %0d..%0d fk=%b lk=%b idx=%0d", i,
                   obs_q[i].a0, obs_q[i].a1, obs_q[i].fk, obs_q[i].lk, obs_q[i].idx);
        end
      end
    end
  endtask

  task automatic test_k_accum();
    run_plan(10, 21, 10, 0, 100);
    checks++;
    if (obs_q.size() != 3) begin
      errors++; $display("FAIL k_accum_count: got %0d expected 3", obs_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_q[i].c0 != 16'(i * 10) || obs_q[i].c1 != 16'((i == 2) ? 20 : i * 10 + 9) ||
            obs_q[i].fk !== (i == 0) || obs_q[i].lk !== (i == 2)) begin
          errors++;
          $display("FAIL k_accum_tile%0d: got k %0d..%0d fk=%b lk=%b", i,
                   obs_q[i].c0, obs_q[i].c1, obs_q[i].fk, obs_q[i].lk);
        end
      end
    end
  endtask

  task automatic test_loop_order();
    int r0[2][4] = '{'{0, 10, 0, 10}, '{0, 0, 10, 10}};
    int c0[2][4] = '{'{0, 0, 10, 10}, '{0, 10, 0, 10}};
    for (int o = 0; o < 2; o++) begin
      run_plan(20, 10, 20, o[0], 100);
      checks++;
      if (obs_q.size() != 4) begin
        errors++; $display("FAIL loop_order%0d_count: got %0d expected 4", o, obs_q.size());
      end else begin
        for (int i = 0; i < 4; i++) begin
          checks++;
          if (obs_q[i].a0 != 16'(r0[o][i]) || obs_q[i].a1 != 16'(r0[o][i] + 9) ||
              obs_q[i].b0 != 16'(c0[o][i]) || obs_q[i].b1 != 16'(c0[o][i] + 9)) begin
            errors++;
            $display("FAIL loop_order%0d_tile%0d: got rows %0d..%0d cols %0d..%0d expected rows %0d.. cols %0d..",
                     o, i, obs_q[i].a0, obs_q[i].a1, obs_q[i].b0, obs_q[i].b1, r0[o][i], c0[o][i]);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    tile_t held;
    build_plan(25, 10, 10, 0);
    launch(25, 10, 10, 0);
    tile_ready = 1;
    obs_q.push_back(cur_tile());
    @(negedge clk);
    tile_ready = 0;
    held = cur_tile();
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin start = 1; mat_m = 16'd99; order = 1; end
      @(negedge clk);
      start = 0;
      checks++;
      if (tile_valid !== 1 || cur_tile() !== held) begin
        errors++;
        $display("FAIL backpressure_hold%0d: got valid=%b tile=%h expected %h", c, tile_valid, cur_tile(), held);
      end
    end
    collect(50);
    checks++;
    if (timed_out || obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL backpressure_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL backpressure_tile%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reject();
    build_plan(5, 0, 5, 0);
    launch(5, 0, 5, 0);
    checks++;
    if (done !== 1 || err !== 1 || busy !== 0 || tile_valid !== 0) begin
      errors++;
      $display("FAIL reject_pulse: got done=%b err=%b busy=%b valid=%b expected 1 1 0 0", done, err, busy, tile_valid);
    end
    @(negedge clk);
    checks++;
    if (done !== 0 || err !== 0 || tile_valid !== 0) begin
      errors++; $display("FAIL reject_after: got done=%b err=%b valid=%b expected 0 0 0", done, err, tile_valid);
    end
  endtask

  task automatic test_reset_mid();
    launch(25, 10, 10, 0);
    tile_ready = 1;
    @(negedge clk);
    tile_ready = 0;
    checks++;
    if (tile_valid !== 1 || tile_idx !== 16'd1) begin
      errors++; $display("FAIL reset_mid_second: got valid=%b idx=%0d expected 1 1", tile_valid, tile_idx);
    end
    reset_n = 0;
    @(negedge clk);
    checks++;
    if (tile_valid !== 0 || tile_idx !== 16'd0 || busy !== 0) begin
      errors++; $display("FAIL reset_mid_clear: got valid=%b idx=%0d busy=%b expected 0 0 0", tile_valid, tile_idx, busy);
    end
    reset_n = 1;
    run_plan(25, 10, 10, 0, 100);
    checks++;
    if (obs_q.size() != exp_q.size() || obs_q[0] !== exp_q[0] || obs_q[2] !== exp_q[2]) begin
      errors++; $display("FAIL reset_mid_replay: got %0d tiles expected %0d", obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_random();
    int m, k, n, bad;
    bit o;
    for (int it = 0; it < 10; it++) begin
      m = $urandom_range(45, 1); k = $urandom_range(45, 1); n = $urandom_range(45, 1);
      o = 1'($urandom_range(1));
      run_plan(m, k, n, o, 60);
      bad = 0;
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
        if (obs_q[i] !== exp_q[i]) bad++;
      checks++;
      if (timed_out || !got_done || got_err || obs_q.size() != exp_q.size() || bad != 0) begin
        errors++;
        $display("FAIL random_plan%0d: M=%0d K=%0d N=%0d ord=%0d got %0d tiles (%0d wrong) expected %0d",
                 it, m, k, n, o, obs_q.size(), bad, exp_q.size());
      end
    end
  endtask

  task automatic test_big();
    int bad;
    run_plan(65535, 5, 3, 1, 100);
    bad = 0;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      if (obs_q[i] !== exp_q[i]) bad++;
    checks++;
    if (timed_out || obs_q.size() != 6554 || bad != 0 || obs_q[$].a1 != 16'd65534) begin
      errors++;
      $display("FAIL big_dim: got %0d tiles (%0d wrong) expected 6554 ending at row 65534", obs_q.size(), bad);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_row_split();
    test_k_accum();
    test_loop_order();
    test_backpressure();
    test_reject();
    test_reset_mid();
    test_random();
    test_big();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sys_array_tile_planner.md
# sys_array_tile_planner

Streaming successor to the one-shot matrix split planner. The block takes the dimensions of a product O[M×N] = A[M×K] · B[K×N] and emits, one per valid/ready handshake, the inclusive index ranges of every sub-problem that fits the systolic array. K is always the innermost loop, and first/last flags let the downstream accumulator sum partial products. The outer loop order is selectable. It sits between the host/config registers and the array sequencer, and replaces the fixed-size task table with a backpressured tile stream.

## Interface
- DIM_W, 16, width of every dimension and index field
- TILE_M, 10, maximum A rows per tile (array rows)
- TILE_K, 10, maximum A columns / B rows per tile (array columns)
- TILE_N, 10, maximum B columns per tile
- CNT_W, 16, width of tile_idx
- clk  in  1  clock; single clock domain
- reset_n  in  1  synchronous, active-low reset
- start  in  1  begin planning; sampled only in IDLE
- mat_m, mat_k, mat_n  in  DIM_W each  matrix dimensions; latched on accepted start
- order  in  1  loop order, latched on start: 0 = N outer, M middle, K inner; 1 = M outer, N middle, K inner
- tile_valid  out  1  tile fields valid
- tile_ready  in  1  consumer accepts tile
- a_row0, a_row1  out  DIM_W  inclusive A/O row range
- k0, k1  out  DIM_W  inclusive A column / B row range
- b_col0, b_col1  out  DIM_W  inclusive B/O column range
- first_k, last_k  out  1  tile is the first / last K slice for its (row, col) output block
- tile_idx  out  CNT_W  sequence number of the tile, starting at 0
- busy  out  1  plan in progress
- done  out  1  one-cycle pulse at end of plan
- err  out  1  one-cycle pulse with done when the plan is rejected

## Operation
- States: IDLE, EMIT, DONE.
- IDLE:
  - start=1 latches the dimensions and order.
  - Any dimension equal to 0 -> go to DONE with err=1; no tile is emitted.
  - Otherwise go to EMIT with m0=k0=n0=0 and tile_idx=0.
- EMIT:
  - tile_valid=1. Fields are computed from the base counters (m0, k0, n0):
    - a_row1 = min(m0+TILE_M, mat_m) − 1
    - k1 = min(k0+TILE_K, mat_k) − 1
    - b_col1 = min(n0+TILE_N, mat_n) − 1
  - All sums are computed at DIM_W+1 bits, so there is no overflow for dimensions up to 2^DIM_W − 1.
  - first_k = (k0 == 0); last_k = (k0+TILE_K ≥ mat_k).
- Advance happens only on tile_valid && tile_ready:
  - K advances first. On K wrap, k0 returns to 0 and the middle loop advances.
  - On middle wrap, the middle counter returns to 0 and the outer loop advances.
  - tile_idx increments by 1 (wraps modulo 2^CNT_W).
- Accepting the last tile (last_k and both the middle and outer loops at their final base) -> DONE.
- DONE lasts exactly one cycle:
  - done=1; err=1 only on the reject path.
  - start is ignored; the next state is IDLE.
- start is ignored while in EMIT or DONE. Changing mat_* or order while busy has no effect.
- Reset at any point returns to IDLE and clears all counters; the tile in flight is discarded.

## Timing
- Reset values: tile_valid=0, busy=0, done=0, err=0, tile_idx=0, and all range fields and flags 0.
- All outputs are registered.
- start sampled at cycle t:
  - The first tile is presented with tile_valid=1 at t+1 and busy=1 from t+1.
  - On reject, done=err=1 at t+1, busy stays 0, and tile_valid never rises.
- Throughput: one tile per cycle while tile_ready=1. The next tile's fields appear the cycle after the handshake, with no bubble.
- Backpressure: while tile_valid=1 and tile_ready=0, every output field holds stable.
- Last handshake at cycle c:
  - tile_valid=0 and busy=0 at c+1.
  - done=1 at c+1 only.
  - IDLE at c+2, where start is accepted again.
- tile_ready while tile_valid=0 has no effect.

## Test plan
- **Single tile.** M=K=N=10, order 0 -> exactly one tile: rows 0..9, k 0..9, cols 0..9, first_k=last_k=1, tile_idx=0. done pulses the cycle after the handshake.
- **Row split.** M=25, K=10, N=10 -> 3 tiles with rows 0–9, 10–19, 20–24. Each has first_k=last_k=1; tile_idx runs 0,1,2.
- **K accumulation.** M=10, K=21, N=10 -> 3 tiles with k ranges 0–9, 10–19, 20–20. first_k is 1,0,0 and last_k is 0,0,1.
- **Loop order.** M=20, K=10, N=20:
  - order 0 -> (rows, cols) sequence (0–9,0–9), (10–19,0–9), (0–9,10–19), (10–19,10–19).
  - order 1 -> (0–9,0–9), (0–9,10–19), (10–19,0–9), (10–19,10–19).
- **Backpressure and ignored start.** Case M=25 (row split) with tile_ready low for 5 cycles and start pulsed during EMIT:
  - The held tile's fields are unchanged for all 5 cycles.
  - The sequence is unaltered and no restart occurs.
  - Random ready toggling still yields exactly 3 handshakes.
- **Reject and reset.**
  - mat_k=0 -> done=err=1 at t+1 and no tile_valid.
  - reset_n low during the second tile of the row-split case -> tile_valid=0 and tile_idx=0 next cycle. A new start replays from tile 0.
